// File: rtl/elevator_ctrl_if.sv
// Request/clear bundle between the button latch block (buttons_res) and the
// car-motion controller. Hall up calls exist on floors 0..W-2, hall down
// calls on floors 1..W-1.
interface elevator_ctrl_if #(
   parameter int unsigned BUTTONS_WIDTH = 8
);
   logic [BUTTONS_WIDTH-1:0] active_in_levels;
   logic [BUTTONS_WIDTH-2:0] active_out_up_levels;
   logic [BUTTONS_WIDTH-1:1] active_out_down_levels;
   logic [BUTTONS_WIDTH-1:0] inactivate_in_levels;
   logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels;
   logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels;

   // Controller side: reads latched requests, issues clear pulses.
   modport master (
      input  active_in_levels,
      input  active_out_up_levels,
      input  active_out_down_levels,
      output inactivate_in_levels,
      output inactivate_out_up_levels,
      output inactivate_out_down_levels
   );

   // Button latch side: presents requests, consumes clear pulses.
   modport slave (
      output active_in_levels,
      output active_out_up_levels,
      output active_out_down_levels,
      input  inactivate_in_levels,
      input  inactivate_out_up_levels,
      input  inactivate_out_down_levels
   );
endinterface

// File: rtl/elevator_ctrl.sv
// SCAN (collective) car-motion controller. Moves one floor every FLOOR_TICKS
// cycles, holds the door for DOOR_TICKS cycles, and clears served requests
// with single-cycle pulses back to the button latch block.
module elevator_ctrl #(
   parameter int unsigned BUTTONS_WIDTH = 8,
   parameter int unsigned FLOOR_BITS    = 3,
   parameter int unsigned FLOOR_TICKS   = 16,
   parameter int unsigned DOOR_TICKS    = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   elevator_ctrl_if.master       buttons,
   output logic [FLOOR_BITS-1:0] current_floor,
   output logic                  direction_up,
   output logic                  moving,
   output logic                  door_open
);
   localparam int unsigned W    = BUTTONS_WIDTH;
   localparam int unsigned TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
   localparam int unsigned CW   = $clog2(TMAX);

   typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

   state_t                state, state_nxt;
   logic [CW-1:0]         tick, tick_nxt;
   logic [FLOOR_BITS-1:0] floor_nxt, arr_floor, door_f;
   logic                  dir_nxt, moving_nxt, door_nxt;
   logic [W-1:0]          clr_in_q, clr_in_nxt, oh, req;
   logic [W-2:0]          clr_up_q, clr_up_nxt;
   logic [W-1:1]          clr_dn_q, clr_dn_nxt;
   logic                  pend, fwd_cur, back_cur, stop_here;
   logic                  floor_end, door_end, rearm;

   // Any request strictly above (up=1) or strictly below (up=0) floor f.
   function automatic logic any_beyond(input logic [W-1:0] r,
                                       input logic [FLOOR_BITS-1:0] f,
                                       input logic up);
      logic hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < W; i++) begin
         if (up ? (i > 32'(f)) : (i < 32'(f))) hit = hit | r[i];
      end
      return hit;
   endfunction

   // Hall call at floor f whose direction matches the sweep.
   function automatic logic hall_match(input logic [FLOOR_BITS-1:0] f, input logic up);
      logic [W-1:0] up_ext, dn_ext;
      up_ext = {1'b0, buttons.active_out_up_levels};
      dn_ext = {buttons.active_out_down_levels, 1'b0};
      return up ? up_ext[f] : dn_ext[f];
   endfunction

   // Request decode shared by the next-state and output logic.
   always_comb begin
      req = buttons.active_in_levels
          | {1'b0, buttons.active_out_up_levels}
          | {buttons.active_out_down_levels, 1'b0};
      pend      = |req;
      fwd_cur   = any_beyond(req, current_floor, direction_up);
      back_cur  = any_beyond(req, current_floor, ~direction_up);
      arr_floor = (state == MOVE_DOWN) ? current_floor - FLOOR_BITS'(1)
                                       : current_floor + FLOOR_BITS'(1);
      stop_here = buttons.active_in_levels[arr_floor] | hall_match(arr_floor, direction_up)
                | ~any_beyond(req, arr_floor, direction_up);
      floor_end = (tick == CW'(FLOOR_TICKS - 1));
      door_end  = (tick == CW'(DOOR_TICKS - 1));
      // Re-arm only once the previous clear pulse is gone, otherwise the
      // still-latched request would extend every door cycle.
      rearm     = (state == DOOR_OPEN)
                & ~(|clr_in_q | |clr_up_q | |clr_dn_q)
                & (buttons.active_in_levels[current_floor] | hall_match(current_floor, direction_up));
   end

   // State and all registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         tick          <= '0;
         current_floor <= '0;
         direction_up  <= 1'b1;
         moving        <= 1'b0;
         door_open     <= 1'b0;
         clr_in_q      <= '0;
         clr_up_q      <= '0;
         clr_dn_q      <= '0;
      end else begin
         state         <= state_nxt;
         tick          <= tick_nxt;
         current_floor <= floor_nxt;
         direction_up  <= dir_nxt;
         moving        <= moving_nxt;
         door_open     <= door_nxt;
         clr_in_q      <= clr_in_nxt;
         clr_up_q      <= clr_up_nxt;
         clr_dn_q      <= clr_dn_nxt;
      end
   end

   // SCAN next-state selection.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req[current_floor]) state_nxt = DOOR_OPEN;
            else if (fwd_cur)       state_nxt = direction_up ? MOVE_UP : MOVE_DOWN;
            else if (back_cur)      state_nxt = direction_up ? MOVE_DOWN : MOVE_UP;
         end
         MOVE_UP, MOVE_DOWN: begin
            if (floor_end) begin
               if (!pend)          state_nxt = IDLE;
               else if (stop_here) state_nxt = DOOR_OPEN;
            end
         end
         DOOR_OPEN: begin
            if (!rearm && door_end) begin
               if (fwd_cur)       state_nxt = direction_up ? MOVE_UP : MOVE_DOWN;
               else if (back_cur) state_nxt = direction_up ? MOVE_DOWN : MOVE_UP;
               else               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of counter, floor, direction and clear pulses.
   always_comb begin
      floor_nxt  = current_floor;
      dir_nxt    = direction_up;
      tick_nxt   = tick + CW'(1);
      clr_in_nxt = '0;
      clr_up_nxt = '0;
      clr_dn_nxt = '0;
      door_f     = (state == MOVE_UP || state == MOVE_DOWN) ? arr_floor : current_floor;
      oh         = W'(1) << door_f;
      case (state)
         IDLE: tick_nxt = '0;
         MOVE_UP, MOVE_DOWN: begin
            if (floor_end) begin
               tick_nxt  = '0;
               floor_nxt = arr_floor;
            end
         end
         DOOR_OPEN: if (rearm || door_end) tick_nxt = '0;
         default: tick_nxt = '0;
      endcase
      if (state_nxt == MOVE_UP)   dir_nxt = 1'b1;
      if (state_nxt == MOVE_DOWN) dir_nxt = 1'b0;
      if (state != DOOR_OPEN && state_nxt == DOOR_OPEN) begin
         clr_in_nxt = oh;
         if (direction_up) clr_up_nxt = oh[W-2:0];
         else              clr_dn_nxt = oh[W-1:1];
         // End of sweep: both hall calls here are served and the sweep turns.
         if (!any_beyond(req, door_f, direction_up)) begin
            clr_up_nxt = oh[W-2:0];
            clr_dn_nxt = oh[W-1:1];
            dir_nxt    = ~direction_up;
         end
      end else if (rearm) begin
         clr_in_nxt = oh;
         if (direction_up) clr_up_nxt = oh[W-2:0];
         else              clr_dn_nxt = oh[W-1:1];
      end
      moving_nxt = (state_nxt == MOVE_UP) || (state_nxt == MOVE_DOWN);
      door_nxt   = (state_nxt == DOOR_OPEN);
   end

   assign buttons.inactivate_in_levels       = clr_in_q;
   assign buttons.inactivate_out_up_levels   = clr_up_q;
   assign buttons.inactivate_out_down_levels = clr_dn_q;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with FLOOR_TICKS=4, DOOR_TICKS=3, 8 floors.
// The bench holds the request latches itself and drops a bit whenever the
// controller pulses the matching clear line.
module tb_elevator_ctrl;
   localparam int unsigned W = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   elevator_ctrl_if #(.BUTTONS_WIDTH(W)) bus ();

   logic [2:0]   current_floor;
   logic         direction_up, moving, door_open;
   logic [W-1:0] in_l = '0;
   logic [W-2:0] up_l = '0;
   logic [W-1:1] dn_l = '0;
   int           tests = 0;
   int           fails = 0;
   int           in_pulses = 0;
   int           door_cycles = 0;

   assign bus.active_in_levels       = in_l;
   assign bus.active_out_up_levels   = up_l;
   assign bus.active_out_down_levels = dn_l;

   elevator_ctrl #(
      .BUTTONS_WIDTH(W),
      .FLOOR_BITS(3),
      .FLOOR_TICKS(4),
      .DOOR_TICKS(3)
   ) dut (
      .clock(clock),
      .reset(reset),
      .buttons(bus),
      .current_floor(current_floor),
      .direction_up(direction_up),
      .moving(moving),
      .door_open(door_open)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; sample at the falling edge and apply clear pulses to the latches.
   task automatic cyc();
      @(posedge clock);
      @(negedge clock);
      if (door_open) door_cycles++;
      if (|bus.inactivate_in_levels) in_pulses++;
      in_l = in_l & ~bus.inactivate_in_levels;
      up_l = up_l & ~bus.inactivate_out_up_levels;
      dn_l = dn_l & ~bus.inactivate_out_down_levels;
   endtask

   task automatic do_reset();
      in_l  = '0;
      up_l  = '0;
      dn_l  = '0;
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic wait_close(input string tag);
      int n = 0;
      while (door_open && n < 50) begin cyc(); n++; end
      chk({tag, "_closed"}, 32'(door_open), 32'd0);
   endtask

   // Wait for the next door opening and check the floor it opened at.
   task automatic wait_door(input string tag, input int exp_floor);
      int n = 0;
      while (door_open && n < 50) begin cyc(); n++; end
      while (!door_open && n < 300) begin cyc(); n++; end
      chk({tag, "_door"}, 32'(door_open), 32'd1);
      chk({tag, "_floor"}, 32'(current_floor), 32'(exp_floor));
   endtask

   task automatic wait_floor(input string tag, input int f);
      int n = 0;
      while (32'(current_floor) != 32'(f) && n < 200) begin cyc(); n++; end
      chk(tag, 32'(current_floor), 32'(f));
   endtask

   initial begin
      // Reset values
      cyc();
      cyc();
      chk("rst_floor", 32'(current_floor), 32'd0);
      chk("rst_dir", 32'(direction_up), 32'd1);
      chk("rst_moving", 32'(moving), 32'd0);
      chk("rst_door", 32'(door_open), 32'd0);
      chk("rst_clr", 32'({bus.inactivate_in_levels, bus.inactivate_out_up_levels,
                          bus.inactivate_out_down_levels}), 32'd0);
      reset = 1'b0;

      // S1: cab call to 5 from 0, one floor every 4 cycles, 3-cycle door
      in_pulses   = 0;
      door_cycles = 0;
      in_l[5] = 1'b1;
      cyc();
      chk("s1_moving", 32'(moving), 32'd1);
      chk("s1_floor0", 32'(current_floor), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         repeat (4) cyc();
         chk("s1_floor", 32'(current_floor), 32'(k));
      end
      chk("s1_door", 32'(door_open), 32'd1);
      chk("s1_moving_stop", 32'(moving), 32'd0);
      chk("s1_clr_in", 32'(bus.inactivate_in_levels), 32'h20);
      chk("s1_dir", 32'(direction_up), 32'd0);
      wait_close("s1");
      chk("s1_door_cycles", 32'(door_cycles), 32'd3);
      chk("s1_in_pulses", 32'(in_pulses), 32'd1);
      repeat (3) cyc();
      chk("s1_idle_floor", 32'(current_floor), 32'd5);
      chk("s1_idle_moving", 32'(moving), 32'd0);
      chk("s1_idle_door", 32'(door_open), 32'd0);

      // S2: up[2] & down[2] & in[6] from floor 0
      do_reset();
      up_l[2] = 1'b1;
      dn_l[2] = 1'b1;
      in_l[6] = 1'b1;
      wait_door("s2_a", 2);
      chk("s2_a_clr_up", 32'(bus.inactivate_out_up_levels), 32'h04);
      chk("s2_a_clr_dn", 32'(bus.inactivate_out_down_levels), 32'h00);
      chk("s2_a_dir", 32'(direction_up), 32'd1);
      chk("s2_a_dn_kept", 32'(dn_l[2]), 32'd1);
      wait_door("s2_b", 6);
      chk("s2_b_clr_in", 32'(bus.inactivate_in_levels), 32'h40);
      chk("s2_b_clr_up", 32'(bus.inactivate_out_up_levels), 32'h40);
      chk("s2_b_clr_dn", 32'(bus.inactivate_out_down_levels), 32'h20);
      chk("s2_b_dir", 32'(direction_up), 32'd0);
      wait_door("s2_c", 2);
      chk("s2_c_clr_dn", 32'(bus.inactivate_out_down_levels), 32'h02);
      chk("s2_c_dn_cleared", 32'(dn_l), 32'h00);
      chk("s2_c_dir", 32'(direction_up), 32'd1);

      // S3: idle at top floor, cab call at the same floor
      do_reset();
      in_l[7] = 1'b1;
      wait_door("s3_a", 7);
      wait_close("s3_a");
      cyc();
      in_pulses   = 0;
      door_cycles = 0;
      in_l[7] = 1'b1;
      cyc();
      chk("s3_door_latency", 32'(door_open), 32'd1);
      chk("s3_clr_in", 32'(bus.inactivate_in_levels), 32'h80);
      chk("s3_floor", 32'(current_floor), 32'd7);
      wait_close("s3_b");
      chk("s3_door_cycles", 32'(door_cycles), 32'd3);
      chk("s3_in_pulses", 32'(in_pulses), 32'd1);
      chk("s3_moving", 32'(moving), 32'd0);
      chk("s3_floor_after", 32'(current_floor), 32'd7);

      // S4: down[3] appears while travelling up to 4
      do_reset();
      in_l[4] = 1'b1;
      wait_floor("s4_f1", 1);
      dn_l[3] = 1'b1;
      wait_door("s4_a", 4);
      chk("s4_a_clr_in", 32'(bus.inactivate_in_levels), 32'h10);
      chk("s4_a_clr_up", 32'(bus.inactivate_out_up_levels), 32'h10);
      chk("s4_a_clr_dn", 32'(bus.inactivate_out_down_levels), 32'h08);
      chk("s4_a_dir", 32'(direction_up), 32'd0);
      wait_door("s4_b", 3);
      chk("s4_b_clr_dn", 32'(bus.inactivate_out_down_levels), 32'h04);
      chk("s4_b_dn_cleared", 32'(dn_l), 32'h00);

      // S5: request withdrawn mid-move
      do_reset();
      in_l[6] = 1'b1;
      wait_floor("s5_f3", 3);
      in_l[6] = 1'b0;
      wait_floor("s5_f4", 4);
      chk("s5_door", 32'(door_open), 32'd0);
      chk("s5_moving", 32'(moving), 32'd0);
      repeat (5) cyc();
      chk("s5_floor_hold", 32'(current_floor), 32'd4);
      chk("s5_door_hold", 32'(door_open), 32'd0);

      // S6: asynchronous reset during a move
      do_reset();
      in_l[6] = 1'b1;
      wait_floor("s6_f3", 3);
      chk("s6_pre_moving", 32'(moving), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("s6_floor", 32'(current_floor), 32'd0);
      chk("s6_dir", 32'(direction_up), 32'd1);
      chk("s6_moving", 32'(moving), 32'd0);
      chk("s6_door", 32'(door_open), 32'd0);
      chk("s6_clr", 32'({bus.inactivate_in_levels, bus.inactivate_out_up_levels,
                         bus.inactivate_out_down_levels}), 32'd0);
      in_l = '0;
      cyc();
      reset = 1'b0;
      cyc();
      chk("s6_after_moving", 32'(moving), 32'd0);
      chk("s6_after_floor", 32'(current_floor), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
